// File: rtl/expmul_dispatch_pkg.sv
// expmul_dispatch_pkg: shared score/vector/tag types and constants for the exp-multiply dispatcher
package expmul_dispatch_pkg;
  localparam int MAX_EMBEDDING_DIM = 3;
  typedef logic signed [7:0] SCORE_QT;
  typedef logic signed [15:0] EXPMUL_VSHIFT_QT;
  typedef EXPMUL_VSHIFT_QT [MAX_EMBEDDING_DIM:0] EXPMUL_VROW_T;
  typedef enum logic {EM_RESCALE = 1'b0, EM_WEIGHT = 1'b1} EXPMUL_TAG_T;
  localparam SCORE_QT SCORE_NEG_INF = SCORE_QT'(8'h80);
endpackage

// File: rtl/expmul_dispatch.sv
// expmul_dispatch: online-softmax RESCALE/WEIGHT request issuer; EXPMUL_RESCALE_SKIP_EN drops no-op rescales
module expmul_dispatch
  import expmul_dispatch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         score_vld_in,
  output logic         score_rdy_out,
  input  SCORE_QT      score_in,
  input  logic         last_in,
  input  EXPMUL_VROW_T v_in,
  input  EXPMUL_VROW_T acc_in,
  output logic         em_vld_out,
  input  logic         em_rdy_in,
  output SCORE_QT      em_a_out,
  output SCORE_QT      em_b_out,
  output EXPMUL_VROW_T em_v_out,
  output EXPMUL_TAG_T  em_tag_out,
  output logic         em_last_out,
  output SCORE_QT      row_max_out
);
  localparam logic [1:0] IDLE = 2'd0, RESCALE = 2'd1, WEIGHT = 2'd2;
  logic [1:0] state_q, state_d;
  SCORE_QT m_q, m_d, m_old_q, m_old_d, s_q, s_d, m_new;
  EXPMUL_VROW_T v_q, v_d, acc_q, acc_d;
  logic last_q, last_d, skip, score_hs, row_done;
  assign score_rdy_out = state_q == IDLE;
  assign score_hs = score_vld_in && score_rdy_out;
  assign row_done = state_q == WEIGHT && em_rdy_in && last_q;
  assign m_new = score_in > m_q ? score_in : m_q;
`ifdef EXPMUL_RESCALE_SKIP_EN
  logic first_q;
  always_ff @(posedge clk)
    first_q <= rst ? 1'b1 : row_done ? 1'b1 : score_hs ? 1'b0 : first_q;
  assign skip = first_q || m_new == m_q;
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    state_d = score_hs ? (skip ? WEIGHT : RESCALE) :
              state_q == RESCALE ? (em_rdy_in ? WEIGHT : RESCALE) :
              state_q == WEIGHT ? (em_rdy_in ? IDLE : WEIGHT) : IDLE;
    m_d = score_hs ? m_new : row_done ? SCORE_NEG_INF : m_q;
    m_old_d = score_hs ? m_q : m_old_q;
    s_d = score_hs ? score_in : s_q;
    v_d = score_hs ? v_in : v_q;
    acc_d = score_hs ? acc_in : acc_q;
    last_d = score_hs ? last_in : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q <= SCORE_NEG_INF;
      m_old_q <= '0;
      s_q <= '0;
      v_q <= '0;
      acc_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      m_old_q <= m_old_d;
      s_q <= s_d;
      v_q <= v_d;
      acc_q <= acc_d;
      last_q <= last_d;
    end
  end
  // m_q already holds m_new while a request is outstanding, so it doubles as operand b
  assign em_vld_out = state_q == RESCALE || state_q == WEIGHT;
  assign em_tag_out = state_q == WEIGHT ? EM_WEIGHT : EM_RESCALE;
  assign em_a_out = state_q == RESCALE ? m_old_q : state_q == WEIGHT ? s_q : '0;
  assign em_b_out = em_vld_out ? m_q : '0;
  assign em_v_out = state_q == RESCALE ? acc_q : state_q == WEIGHT ? v_q : '0;
  assign em_last_out = state_q == WEIGHT && last_q;
  assign row_max_out = m_q;
endmodule
